// File: rtl/encoder_maxpool2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-ordered (row, col, channel) feature map.
// One row buffer of partial maxima; single-entry output register with valid/ready on both sides.
module encoder_maxpool2x2 #(
    parameter int unsigned FEATURE_WIDTH  = 16,
    parameter int unsigned FEATURE_HEIGHT = 16,
    parameter int unsigned CHANNELS       = 256,
    parameter int unsigned DATA_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned COL_W  = $clog2(FEATURE_WIDTH);
    localparam int unsigned ROW_W  = $clog2(FEATURE_HEIGHT);
    localparam int unsigned DEPTH  = (FEATURE_WIDTH / 2) * CHANNELS;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TOTAL  = FEATURE_WIDTH * FEATURE_HEIGHT * CHANNELS;
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CH_W-1:0]       r_ch;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [CNT_W-1:0]      r_in_cnt;
    logic [DATA_WIDTH-1:0] r_buf [DEPTH];
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;

    logic                  w_run;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_ch_last;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_row_odd;
    logic                  w_col_odd;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_WIDTH-1:0] w_buf_rd;
    logic [DATA_WIDTH-1:0] w_max;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_out_hs && r_out_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_run  = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   begin w_run = 1'b1; w_busy = 1'b1; end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign in_ready = w_run && (r_in_cnt < CNT_W'(TOTAL)) && (!r_out_valid || out_ready);
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    assign w_ch_last  = (r_ch  == CH_W'(CHANNELS - 1));
    assign w_col_last = (r_col == COL_W'(FEATURE_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(FEATURE_HEIGHT - 1));
    assign w_row_odd  = r_row[0];
    assign w_col_odd  = r_col[0];

    assign w_addr   = ADDR_W'(r_col >> 1) * ADDR_W'(CHANNELS) + ADDR_W'(r_ch);
    assign w_buf_rd = r_buf[w_addr];
    assign w_max    = ($signed(in_data) > $signed(w_buf_rd)) ? in_data : w_buf_rd;

    // Raster position counters, cleared when a frame is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_in_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_ch     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_in_cnt <= '0;
        end else if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + CNT_W'(1);
            if (w_ch_last) begin
                r_ch <= '0;
                if (w_col_last) begin
                    r_col <= '0;
                    if (!w_row_last) r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else begin
                r_ch <= r_ch + CH_W'(1);
            end
        end
    end

    // Row buffer: window top-left overwrites stale data, so no clear is needed
    always_ff @(posedge clk) begin
        if (w_in_hs && !(w_row_odd && w_col_odd)) begin
            r_buf[w_addr] <= (!w_row_odd && !w_col_odd) ? in_data : w_max;
        end
    end

    // Output register; a load in the same cycle as a handshake keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_hs && w_row_odd && w_col_odd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_max;
            r_out_last  <= w_row_last && w_col_last && w_ch_last;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule

// File: tb/tb_encoder_maxpool2x2.sv
// Scoreboard bench for encoder_maxpool2x2: a 4x4x2 instance for directed frames and an
// 8x8x3 instance for random valid/ready traffic, both checked against a direct 2x2 max model.
module tb_encoder_maxpool2x2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Instance A: 4x4x2
    logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy, a_done;
    logic [15:0] a_in_data, a_out_data;
    // Instance B: 8x8x3
    logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy, b_done;
    logic [15:0] b_in_data, b_out_data;

    encoder_maxpool2x2 #(.FEATURE_WIDTH(4), .FEATURE_HEIGHT(4), .CHANNELS(2), .DATA_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy), .done(a_done));

    encoder_maxpool2x2 #(.FEATURE_WIDTH(8), .FEATURE_HEIGHT(8), .CHANNELS(3), .DATA_WIDTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy), .done(b_done));

    // Scoreboard entries: {last, data}
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    int a_done_cnt = 0, a_done_cyc = 0, a_last_cyc = -10;
    int b_done_cnt = 0, b_nout = 0;

    // Reference: direct max over each 2x2 window, pushed in output raster order
    function automatic void model(input int w, input int h, input int c, input logic [15:0] d[$], input bit sel);
        logic signed [15:0] m, v;
        logic [16:0] e;
        for (int r = 0; r < h / 2; r++)
            for (int x = 0; x < w / 2; x++)
                for (int ch = 0; ch < c; ch++) begin
                    m = d[((2 * r) * w + 2 * x) * c + ch];
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = d[((2 * r + dy) * w + 2 * x + dx) * c + ch];
                            if (v > m) m = v;
                        end
                    e = {(r == h / 2 - 1) && (x == w / 2 - 1) && (ch == c - 1), m};
                    if (sel) qb.push_back(e);
                    else     qa.push_back(e);
                end
    endfunction

    // Output monitors
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) check("a_unexpected_out", 32'(qa.size()), 32'd1);
                else begin
                    e = qa.pop_front();
                    check("a_data", 32'(a_out_data), 32'(e[15:0]));
                    check("a_last", 32'(a_out_last), 32'(e[16]));
                    if (a_out_last) a_last_cyc = cyc;
                end
            end
            if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
            if (b_out_valid && b_out_ready) begin
                b_nout++;
                if (qb.size() == 0) check("b_unexpected_out", 32'(qb.size()), 32'd1);
                else begin
                    e = qb.pop_front();
                    check("b_data", 32'(b_out_data), 32'(e[15:0]));
                    check("b_last", 32'(b_out_last), 32'(e[16]));
                end
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic start_a;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        check("a_busy_after_start", 32'(a_busy), 32'd1);
        check("a_in_ready_after_start", 32'(a_in_ready), 32'd1);
    endtask

    task automatic drive_a(input logic [15:0] d[$], output int ncyc);
        int i = 0;
        logic acc;
        ncyc = 0;
        a_in_valid = 1'b1;
        while (i < d.size() && ncyc < 2000) begin
            a_in_data = d[i];
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk); #1;
            ncyc++;
            if (acc) i++;
        end
        a_in_valid = 1'b0;
        check("a_drive_complete", 32'(i), 32'(d.size()));
    endtask

    task automatic wait_done_a(input bit pulse_start);
        int k = 0;
        while (k < 500) begin
            @(negedge clk);
            if (a_done) break;
            k++;
        end
        check("a_done_seen", 32'(a_done), 32'd1);
        check("a_busy_at_done", 32'(a_busy), 32'd0);
        if (pulse_start) a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        check("a_done_latency", 32'(a_done_cyc), 32'(a_last_cyc + 1));
        check("a_done_one_cycle", 32'(a_done), 32'd0);
        check("a_idle_busy", 32'(a_busy), 32'd0);
        check("a_idle_in_ready", 32'(a_in_ready), 32'd0);
        check("a_queue_empty", 32'(qa.size()), 32'd0);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_in_ready"}, 32'(a_in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(a_out_data), 32'd0);
        check({tag, "_out_last"}, 32'(a_out_last), 32'd0);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
        check({tag, "_done"}, 32'(a_done), 32'd0);
    endtask

    initial begin
        logic [15:0] d[$];
        logic [15:0] held;
        int n;
        int g;

        rst_n = 1'b0;
        a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp frame
        d.delete();
        for (int i = 0; i < 32; i++) d.push_back(16'(i));
        model(4, 4, 2, d, 1'b0);
        start_a();
        drive_a(d, n);
        check("ramp_cycles", 32'(n), 32'd32);
        wait_done_a(1'b0);

        // All-negative frame exercises the signed compare
        d.delete();
        for (int i = 0; i < 32; i++) d.push_back(16'hF000 | 16'(i & 8'hFF));
        model(4, 4, 2, d, 1'b0);
        start_a();
        drive_a(d, n);
        wait_done_a(1'b0);

        // Extremes: most-negative against most-positive
        d.delete();
        for (int i = 0; i < 32; i++) d.push_back((i % 3 == 0) ? 16'h7FFF : 16'h8000);
        model(4, 4, 2, d, 1'b0);
        start_a();
        drive_a(d, n);
        wait_done_a(1'b0);

        // Backpressure: stall the first output for 10 cycles
        d.delete();
        for (int i = 0; i < 32; i++) d.push_back(16'(i));
        model(4, 4, 2, d, 1'b0);
        start_a();
        fork
            drive_a(d, n);
            begin
                g = 0;
                while (g < 200) begin
                    @(posedge clk); #1;
                    if (a_out_valid) break;
                    g++;
                end
                a_out_ready = 1'b0;
                held = a_out_data;
                repeat (10) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(a_in_ready), 32'd0);
                    check("bp_out_valid", 32'(a_out_valid), 32'd1);
                    check("bp_out_hold", 32'(a_out_data), 32'(held));
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        wait_done_a(1'b0);

        // Asynchronous reset after 7 inputs
        d.delete();
        for (int i = 0; i < 7; i++) d.push_back(16'(i));
        start_a();
        drive_a(d, n);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean ramp after reset, with start pulsed during busy and coincident with done
        d.delete();
        for (int i = 0; i < 32; i++) d.push_back(16'(i));
        model(4, 4, 2, d, 1'b0);
        start_a();
        fork
            drive_a(d, n);
            begin
                repeat (5) @(posedge clk);
                #1;
                a_start = 1'b1;
                @(posedge clk); #1;
                a_start = 1'b0;
            end
        join
        wait_done_a(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("a_stays_idle", 32'(a_busy), 32'd0);
        check("a_done_total", 32'(a_done_cnt), 32'd5);

        // Random valid/ready traffic on the 8x8x3 instance
        d.delete();
        for (int i = 0; i < 192; i++) d.push_back(16'($urandom));
        model(8, 8, 3, d, 1'b1);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        check("b_busy_after_start", 32'(b_busy), 32'd1);
        fork
            begin
                int i = 0;
                int guard = 0;
                logic acc;
                while (i < 192 && guard < 5000) begin
                    b_in_valid = 1'($urandom_range(0, 1));
                    b_in_data = d[i];
                    @(negedge clk);
                    acc = b_in_valid && b_in_ready;
                    @(posedge clk); #1;
                    guard++;
                    if (acc) i++;
                end
                b_in_valid = 1'b0;
                check("b_drive_complete", 32'(i), 32'd192);
            end
            begin
                int guard = 0;
                while (!b_done && guard < 6000) begin
                    b_out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    guard++;
                end
                b_out_ready = 1'b1;
                check("b_done_reached", 32'(b_done), 32'd1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("b_out_count", 32'(b_nout), 32'd48);
        check("b_done_count", 32'(b_done_cnt), 32'd1);
        check("b_queue_empty", 32'(qb.size()), 32'd0);
        check("b_idle_busy", 32'(b_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_maxpool2x2.md
# encoder_maxpool2x2

Streaming 2×2/stride-2 signed max-pool. It forms the final down-sampling step of the last encoder stage and produces the feature map that the bottleneck consumes. It accepts one 16-bit channel sample per handshake in raster order (row, column, channel innermost) and emits the pooled map in the same order at a quarter of the spatial size. It holds one row-buffer of partial maxima and supports backpressure on both sides.

## Interface
- FEATURE_WIDTH, 16: input map width. Must be even and ≥2.
- FEATURE_HEIGHT, 16: input map height. Must be even and ≥2.
- CHANNELS, 256: channels per pixel. Must be ≥1.
- DATA_WIDTH, 16: sample width, two's complement.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that arms a frame. Ignored while busy.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_data  in  DATA_WIDTH  input sample, signed.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream can accept an output sample.
- out_data  out  DATA_WIDTH  pooled sample, signed.
- out_last  out  1  high together with the final output sample of the frame.
- busy  out  1  frame is armed and not yet finished.
- done  out  1  one-cycle pulse when the frame is complete.

## Operation
- States:
  - IDLE: on start, go to RUN and clear the row/col/ch counters.
  - RUN: after the last output handshake, go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Counters:
  - ch wraps at CHANNELS-1 and then increments col.
  - col wraps at FEATURE_WIDTH-1 and then increments row.
  - row stops at FEATURE_HEIGHT-1.
- Buffer:
  - Depth is (FEATURE_WIDTH/2)·CHANNELS entries of DATA_WIDTH.
  - Address is (col>>1)·CHANNELS + ch.
  - Implemented as a register array or inferred RAM with same-cycle read.
- Per accepted sample, by position in the 2×2 window:
  - (row even, col even): write in_data. No compare; this overwrites stale data, so the buffer never needs clearing.
  - (row even, col odd), (row odd, col even): write signed max(buf, in_data).
  - (row odd, col odd): load the output register with signed max(buf, in_data). No buffer write.
- Compare is a signed DATA_WIDTH compare. Ties select either operand, which is bit-identical. 0x8000 is the most-negative value; no saturation is needed.
- Output register is single-entry:
  - out_valid sets when it is loaded and clears on an out_valid&&out_ready handshake.
  - Simultaneous load and handshake in one cycle is allowed and keeps out_valid high.
- in_ready = (state==RUN) && input count < total && (!out_valid || out_ready). An output is never dropped or overwritten.
- out_last is set for output index (FEATURE_WIDTH/2)·(FEATURE_HEIGHT/2)·CHANNELS − 1.
- in_valid in IDLE or DONE is not accepted (in_ready=0).
- Reset asserted mid-frame returns to IDLE with all outputs at reset values. The next start begins a clean frame.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Counters are 0 and the state is IDLE.
- start sampled high in IDLE: busy=1 and in_ready=1 from the next cycle.
- Latency: an out sample is valid the cycle after the handshake of its (odd row, odd col) input.
- Throughput is one input per cycle when out_ready is held high.
- done is high the cycle after the out_last handshake; busy falls in the same cycle.
- A start pulse coincident with done, or during busy, is ignored.

## Test plan
- Ramp, W=H=4, C=2, in_data=linear index 0..31, out_ready=1: outputs 10,11,14,15,26,27,30,31. out_last is on 31. done rises the cycle after; 32 inputs are accepted in 32 cycles.
- All-negative input (0xF000 | idx&0xFF): outputs are the signed max, for example 0xF00B not 0xF000. Checks the signed compare. 0x8000 mixed with 0x7FFF gives 0x7FFF.
- Backpressure: hold out_ready=0 for 10 cycles after the first output. in_ready must drop the cycle after that output is loaded, and the data must stay stable. Release: no loss or duplication, ordering preserved.
- Random in_valid/out_ready toggling at 50% with C=3 and W=H=8, checked against a reference model: all 48 outputs match and exactly one done pulse occurs.
- Reset mid-frame after 7 inputs: outputs go to reset values immediately (asynchronous). A new start plus the full ramp frame gives the same results as the first test.
- start pulsed again during busy and coincident with done: no effect. The frame completes normally and the state returns to IDLE.
